// File: rtl/queue_to_axis_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : queue_to_axis_tx
// Description : Drains a registered-output queue (1-cycle read latency) into
//               an AXI4-Stream master through a 2-entry skid FIFO. Tracks
//               packet boundaries, optionally limits tuser to the first beat
//               of each packet, and counts completed packets.
// Ports       : clk, resetn (sync, active-low)
//               q_tdata/q_tkeep/q_tuser/q_tlast  queue head payload
//               q_can_read (in), q_read (out, combinational pop request)
//               m_axis_tdata/tkeep/tuser/tlast/tvalid (out), m_axis_tready (in)
//               pkt_count (out, 32b), in_packet (out)
// Revision    : 1.0 - initial release
// ============================================================================
module queue_to_axis_tx #(
  parameter int TDATA_WIDTH      = 256,
  parameter int TUSER_WIDTH      = 128,
  parameter int TUSER_FIRST_ONLY = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [TDATA_WIDTH-1:0]   q_tdata,
  input  logic [TDATA_WIDTH/8-1:0] q_tkeep,
  input  logic [TUSER_WIDTH-1:0]   q_tuser,
  input  logic                     q_tlast,
  input  logic                     q_can_read,
  output logic                     q_read,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [31:0]              pkt_count,
  output logic                     in_packet
);

  localparam int c_keep_w = TDATA_WIDTH / 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                   r_inflight;
  logic [1:0]             r_count;
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [31:0]            r_pkt_count;

  logic [TDATA_WIDTH-1:0] r_data [2];
  logic [c_keep_w-1:0]    r_keep [2];
  logic [TUSER_WIDTH-1:0] r_user [2];
  logic                   r_last [2];

  logic                   w_pop;
  logic [2:0]             w_reserved;
  logic [2:0]             w_reserved_after_pop;
  logic                   w_head_last;

  // ---------------------------------------------------------------------------
  // Read request: a read is only issued when a slot is guaranteed for it,
  // counting both stored beats and the one already in flight. A pop in the
  // same cycle frees a slot, which is what sustains one beat per cycle.
  // ---------------------------------------------------------------------------
  assign m_axis_tvalid        = (r_count != 2'd0);
  assign w_pop                = m_axis_tvalid & m_axis_tready;
  assign w_reserved           = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_reserved_after_pop = w_reserved - {2'b00, w_pop};
  assign q_read               = resetn & q_can_read & (w_reserved_after_pop < 3'd2);

  // ---------------------------------------------------------------------------
  // Occupancy, pointers and the in-flight marker. The beat requested last
  // cycle is valid on q_* now and is captured at this edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
    end else begin
      r_inflight <= q_read;
      if (r_inflight) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_data[r_wr_ptr] <= q_tdata;
      r_keep[r_wr_ptr] <= q_tkeep;
      r_user[r_wr_ptr] <= q_tuser;
      r_last[r_wr_ptr] <= q_tlast;
    end
  end

  assign w_head_last  = r_last[r_rd_ptr];
  assign m_axis_tdata = m_axis_tvalid ? r_data[r_rd_ptr] : '0;
  assign m_axis_tkeep = m_axis_tvalid ? r_keep[r_rd_ptr] : '0;
  assign m_axis_tlast = m_axis_tvalid & w_head_last;

  generate
    if (TUSER_FIRST_ONLY != 0) begin : g_tuser_first
      // IDLE means the head beat opens a packet.
      assign m_axis_tuser = (m_axis_tvalid && (r_state == IDLE)) ? r_user[r_rd_ptr] : '0;
    end else begin : g_tuser_all
      assign m_axis_tuser = m_axis_tvalid ? r_user[r_rd_ptr] : '0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Packet tracking, advanced only by beats accepted on the master port.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_pop) begin
      case (r_state)
        IDLE:    if (!w_head_last) w_state_nxt = IN_PKT;
        IN_PKT:  if (w_head_last)  w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign in_packet = (r_state == IN_PKT);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pkt_count <= 32'd0;
    end else if (w_pop && w_head_last) begin
      r_pkt_count <= r_pkt_count + 32'd1;
    end
  end

  assign pkt_count = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_queue_to_axis_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_queue_to_axis_tx
// Description : Self-checking bench for queue_to_axis_tx. A behavioural queue
//               feeds two instances (tuser first-beat-only and pass-through);
//               accepted beats are checked against a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_queue_to_axis_tx;

  localparam int DW = 256;
  localparam int KW = 32;
  localparam int UW = 128;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] q_tdata;
  logic [KW-1:0] q_tkeep;
  logic [UW-1:0] q_tuser;
  logic          q_tlast;
  logic          q_can_read;
  logic          m_axis_tready;

  logic          q_read_a, q_read_b;
  logic [DW-1:0] tdata_a, tdata_b;
  logic [KW-1:0] tkeep_a, tkeep_b;
  logic [UW-1:0] tuser_a, tuser_b;
  logic          tlast_a, tlast_b, tvalid_a, tvalid_b;
  logic [31:0]   pkt_a, pkt_b;
  logic          inpkt_a, inpkt_b;

  always #5 clk = ~clk;

  queue_to_axis_tx #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .TUSER_FIRST_ONLY(1)) dut_a (
    .clk(clk), .resetn(resetn),
    .q_tdata(q_tdata), .q_tkeep(q_tkeep), .q_tuser(q_tuser), .q_tlast(q_tlast),
    .q_can_read(q_can_read), .q_read(q_read_a),
    .m_axis_tdata(tdata_a), .m_axis_tkeep(tkeep_a), .m_axis_tuser(tuser_a),
    .m_axis_tlast(tlast_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(m_axis_tready),
    .pkt_count(pkt_a), .in_packet(inpkt_a)
  );

  queue_to_axis_tx #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .TUSER_FIRST_ONLY(0)) dut_b (
    .clk(clk), .resetn(resetn),
    .q_tdata(q_tdata), .q_tkeep(q_tkeep), .q_tuser(q_tuser), .q_tlast(q_tlast),
    .q_can_read(q_can_read), .q_read(q_read_b),
    .m_axis_tdata(tdata_b), .m_axis_tkeep(tkeep_b), .m_axis_tuser(tuser_b),
    .m_axis_tlast(tlast_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(m_axis_tready),
    .pkt_count(pkt_b), .in_packet(inpkt_b)
  );

  beat_t       src[$];
  beat_t       sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          nreads = 0;
  int          first_read_cyc = -1;
  int          first_valid_cyc = -1;
  bit          src_en = 1'b0;
  bit          m_state = 1'b0;
  logic [31:0] m_cnt = 32'd0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_pkt(input int n, input logic [UW-1:0] user, input bit fixed_user,
                         input logic [KW-1:0] last_keep);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < DW / 32; k++) b.data[k*32 +: 32] = $urandom();
      for (int k = 0; k < UW / 32; k++) b.user[k*32 +: 32] = $urandom();
      if (fixed_user) b.user = user;
      b.last = (i == n - 1);
      b.keep = b.last ? last_keep : {KW{1'b1}};
      src.push_back(b);
    end
  endtask

  // Called at posedge+1; checks at posedge+2, then advances one clock and
  // plays the queue side (registered head, valid the cycle after q_read).
  task automatic tick();
    beat_t b;
    logic  rd;
    logic  rst_now;
    #1;
    chk("in_packet", inpkt_a, m_state);
    chk("pkt_count", pkt_a, m_cnt);
    chk("pkt_count_b", pkt_b, m_cnt);
    if (!resetn)     chk("q_read_in_reset", q_read_a, 0);
    if (!q_can_read) chk("q_read_no_data", q_read_a, 0);
    if (tvalid_a && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (tvalid_a && m_axis_tready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        b = sb.pop_front();
        chk("tdata", tdata_a, b.data);
        chk("tkeep", tkeep_a, b.keep);
        chk("tlast", tlast_a, b.last);
        chk("tuser_first", tuser_a, m_state ? '0 : b.user);
        chk("tuser_all", tuser_b, b.user);
        chk("tvalid_b", tvalid_b, 1);
        if (b.last) begin
          m_state = 1'b0;
          m_cnt   = m_cnt + 32'd1;
        end else begin
          m_state = 1'b1;
        end
      end
    end else if (tvalid_a && sb.size() > 0) begin
      chk("stall_data", tdata_a, sb[0].data);
      chk("stall_last", tlast_a, sb[0].last);
    end
    rd      = q_read_a;
    rst_now = !resetn;
    if (rd) begin
      nreads++;
      if (first_read_cyc < 0) first_read_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst_now) begin
      sb.delete();
      src.delete();
      m_state = 1'b0;
      m_cnt   = 32'd0;
    end else if (rd) begin
      if (src.size() == 0) begin
        chk("read_empty_queue", 1, 0);
      end else begin
        b = src.pop_front();
        q_tdata = b.data;
        q_tkeep = b.keep;
        q_tuser = b.user;
        q_tlast = b.last;
        sb.push_back(b);
      end
    end
    q_can_read = src_en && (src.size() > 0);
  endtask

  initial begin
    resetn        = 1'b0;
    m_axis_tready = 1'b0;
    q_can_read    = 1'b0;
    q_tdata       = '0;
    q_tkeep       = '0;
    q_tuser       = '0;
    q_tlast       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    repeat (2) tick();
    resetn = 1'b1;

    // Reset state
    chk("rst_tvalid", tvalid_a, 0);
    chk("rst_tdata", tdata_a, 0);
    chk("rst_tkeep", tkeep_a, 0);
    chk("rst_tuser", tuser_a, 0);
    chk("rst_tlast", tlast_a, 0);
    chk("rst_pkt_count", pkt_a, 0);
    chk("rst_in_packet", inpkt_a, 0);

    // 3-beat packet, tready high: 2-cycle fill latency
    m_axis_tready = 1'b1;
    add_pkt(3, '0, 1'b0, 32'h0000_000F);
    src_en = 1'b1;
    q_can_read = 1'b1;
    first_read_cyc  = -1;
    first_valid_cyc = -1;
    repeat (10) tick();
    chk("fill_latency", first_valid_cyc - first_read_cyc, 2);
    chk("pkt_count_1", pkt_a, 1);

    // Continuous stream with tready toggling
    for (int p = 0; p < 5; p++) add_pkt($urandom_range(1, 5), '0, 1'b0, 32'h0000_00FF);
    q_can_read = 1'b1;
    for (int i = 0; i < 40; i++) begin
      m_axis_tready = (i % 2 == 0);
      tick();
    end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 60 && (sb.size() > 0 || src.size() > 0); i++) tick();
    chk("stream_drained", sb.size() + src.size(), 0);

    // tready low for 10 cycles: exactly two reads, then drain with no bubble
    m_axis_tready = 1'b0;
    add_pkt(6, '0, 1'b0, 32'h0000_FFFF);
    q_can_read = 1'b1;
    nreads = 0;
    repeat (10) tick();
    chk("stall_reads", nreads, 2);
    chk("stall_tvalid", tvalid_a, 1);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("no_bubble", tvalid_a, 1);
      tick();
    end
    repeat (3) tick();
    chk("stall_drained", sb.size(), 0);

    // tuser first-beat-only vs pass-through
    add_pkt(4, 128'hA5, 1'b1, 32'h0000_0003);
    q_can_read = 1'b1;
    repeat (8) tick();
    chk("tuser_pkt_done", sb.size() + src.size(), 0);

    // Reset the cycle after a read with data pending
    m_axis_tready = 1'b0;
    add_pkt(2, '0, 1'b0, 32'h0000_0001);
    q_can_read = 1'b1;
    nreads = 0;
    tick();
    chk("pre_reset_read", nreads, 1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("rr_tvalid", tvalid_a, 0);
    chk("rr_tdata", tdata_a, 0);
    chk("rr_tlast", tlast_a, 0);
    chk("rr_pkt_count", pkt_a, 0);
    chk("rr_in_packet", inpkt_a, 0);
    m_axis_tready = 1'b1;
    repeat (4) tick();
    chk("rr_discarded", tvalid_a, 0);

    // pkt_count wrap
    force dut_a.r_pkt_count = 32'hFFFF_FFFF;
    force dut_b.r_pkt_count = 32'hFFFF_FFFF;
    release dut_a.r_pkt_count;
    release dut_b.r_pkt_count;
    m_cnt = 32'hFFFF_FFFF;
    add_pkt(1, '0, 1'b0, 32'hFFFF_FFFF);
    q_can_read = 1'b1;
    repeat (6) tick();
    chk("wrap_pkt_count", pkt_a, 0);
    chk("wrap_in_packet", inpkt_a, 0);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/queue_to_axis_tx.md
QUEUE_TO_AXIS_TX -- requirements
Module: queue_to_axis_tx

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 256, meaning byte-multiple width of the queue read port and the AXI4-Stream master data.
REQ-002 SHALL have parameter TUSER_WIDTH, default 128, meaning sideband width.
REQ-003 SHALL have parameter TUSER_FIRST_ONLY, default 1, meaning 1 = drive tuser on first beat of a packet only, 0 on later beats; 0 = pass tuser on every beat.
REQ-004 clk  input  1  clock; all logic rising-edge.
REQ-005 resetn  input  1  reset; synchronous, active-low.
REQ-006 q_tdata  input  TDATA_WIDTH  queue head data, registered in queue, valid the cycle after q_read.
REQ-007 q_tkeep  input  TDATA_WIDTH/8  queue head byte enables, contiguous from bit 0.
REQ-008 q_tuser  input  TUSER_WIDTH  queue head sideband.
REQ-009 q_tlast  input  1  queue head end-of-packet.
REQ-010 q_can_read  input  1  queue has a beat available.
REQ-011 q_read  output  1  pop request to queue, combinational.
REQ-012 m_axis_tdata / m_axis_tkeep / m_axis_tuser / m_axis_tlast  output  TDATA_WIDTH / TDATA_WIDTH/8 / TUSER_WIDTH / 1  AXI4-Stream master payload.
REQ-013 m_axis_tvalid  output  1; m_axis_tready  input  1  AXI4-Stream handshake.
REQ-014 pkt_count  output  32  count of packets completed on the master port (tlast beats accepted).
REQ-015 in_packet  output  1  high between an accepted non-last beat and its packet's accepted tlast beat.

Function
REQ-016 Read latency SHALL be exactly 1 cycle: q_read asserted in cycle t captures q_tdata/q_tkeep/q_tuser/q_tlast at the rising edge ending cycle t+1 into the output buffer.
REQ-017 Output buffer SHALL be a 2-entry FIFO; m_axis_* SHALL be driven from its head; m_axis_tvalid = buffer non-empty.
REQ-018 pop SHALL be m_axis_tvalid & m_axis_tready; head payload SHALL remain stable while tvalid=1 and tready=0.
REQ-019 inflight SHALL be a 1-bit register set by q_read and cleared the next cycle; reserved = occupancy + inflight (0..2).
REQ-020 q_read SHALL be q_can_read & ((reserved - pop) < 2); never asserted when q_can_read=0.
REQ-021 With q_can_read and m_axis_tready held high, steady-state throughput SHALL be one beat per cycle after a 2-cycle fill latency (first q_read in cycle 0 -> first tvalid in cycle 2).
REQ-022 Buffer SHALL never overflow: a captured beat with occupancy 2 and no pop is a design error and SHALL be unreachable.
REQ-023 Simultaneous capture and pop SHALL keep occupancy unchanged and preserve order.
REQ-024 Packet FSM states IDLE, IN_PKT: IDLE->IN_PKT on accepted beat with tlast=0; IN_PKT->IDLE on accepted beat with tlast=1; IDLE->IDLE on accepted single-beat packet.
REQ-025 in_packet SHALL equal (state == IN_PKT).
REQ-026 With TUSER_FIRST_ONLY=1, m_axis_tuser SHALL equal the captured tuser when state==IDLE and 0 when state==IN_PKT; with 0, always the captured tuser.
REQ-027 tkeep, tdata, tlast SHALL pass unmodified; no beat SHALL be dropped or duplicated.
REQ-028 pkt_count SHALL increment by 1 on each accepted tlast beat, wrapping 0xFFFFFFFF -> 0.

Reset
REQ-029 While resetn=0 at a clock edge: buffer occupancy 0, inflight 0, state IDLE, pkt_count 0, all m_axis_* outputs 0, in_packet 0.
REQ-030 q_read SHALL be 0 during any cycle in which resetn=0.
REQ-031 A read in flight when reset asserts SHALL be discarded; queue is reset by the same resetn.

Verification
REQ-032 Reset, then 3-beat packet (tkeep 0xFFFFFFFF x2, 0x0000000F with tlast), tready=1 -> beats appear cycles 2,3,4 unchanged; pkt_count=1; in_packet high cycles 3-4 only.
REQ-033 Continuous stream, tready toggling 1,0,1,0 -> no loss/duplication, payload stable during tready=0, q_read never asserted with reserved-pop=2.
REQ-034 tready=0 for 10 cycles, q_can_read=1 -> exactly 2 q_read pulses, occupancy 2, then releasing tready drains in order with no bubble.
REQ-035 TUSER_FIRST_ONLY=1, q_tuser=0xA5 on all beats of a 4-beat packet -> m_axis_tuser 0xA5 on beat 0, 0 on beats 1-3; TUSER_FIRST_ONLY=0 -> 0xA5 on all.
REQ-036 resetn pulsed low the cycle after q_read with data pending -> all outputs 0 next cycle, captured beat discarded, pkt_count 0.
REQ-037 pkt_count preloaded via 2^32-1 single-beat packets (or forced) -> next tlast wraps to 0.
